// File: rtl/cpu_pkg.sv
// Shared ISA constants, FSM state encoding and helpers for the multicycle cpu_core.
package cpu_pkg;

  localparam logic [2:0] OP_MOV   = 3'b110;
  localparam logic [2:0] OP_ALU   = 3'b101;

  localparam logic [1:0] SUB_MOVS = 2'b00;
  localparam logic [1:0] SUB_MOVI = 2'b10;
  localparam logic [1:0] SUB_ADD  = 2'b00;
  localparam logic [1:0] SUB_CMP  = 2'b01;
  localparam logic [1:0] SUB_AND  = 2'b10;
  localparam logic [1:0] SUB_MVN  = 2'b11;

  localparam logic [1:0] SH_PASS  = 2'b00;
  localparam logic [1:0] SH_LSL   = 2'b01;
  localparam logic [1:0] SH_LSR   = 2'b10;
  localparam logic [1:0] SH_ASR   = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GETA, S_GETB, S_EXEC, S_WRITE, S_WIMM
  } state_t;

  // Widest legal datapath is 64; callers truncate to DATA_W.
  function automatic logic [63:0] sext8(input logic [7:0] v);
    return {{56{v[7]}}, v};
  endfunction

endpackage

// File: rtl/regfile_p.sv
// 8-entry register file: two async read ports, one synchronous write port, async clear.
module regfile_p #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [2:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [2:0]        i_raddr_a,
  input  logic [2:0]        i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [7:0][DATA_W-1:0] r_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_mem <= '0;
    else if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/cpu_core.sv
// Multicycle CPU: 16-bit instruction words over a DATA_W datapath, six-instruction ISA,
// undefined-opcode flag and optional status update on every ALU instruction.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter bit STATUS_ALL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic              load,
  input  logic [15:0]       in,
  output logic [DATA_W-1:0] out,
  output logic              N,
  output logic              V,
  output logic              Z,
  output logic              w,
  output logic              ill
);

  localparam int M = DATA_W - 1;

  state_t             r_state, w_next;
  logic [15:0]        r_ir;
  logic [DATA_W-1:0]  r_a, r_b, r_c;
  logic               r_n, r_v, r_z, r_ill;

  logic [2:0]         w_op, w_rn, w_rd, w_rm;
  logic [1:0]         w_sub, w_sh;
  logic [7:0]         w_imm8;
  logic               w_is_movi, w_is_movs, w_is_alu, w_is_cmp, w_is_mvn;
  logic [DATA_W-1:0]  w_rd_a, w_rd_b, w_bs, w_sum, w_diff, w_res, w_imm_ext, w_wdata;
  logic               w_res_v, w_upd, w_we;
  logic [2:0]         w_waddr;

  assign w_op   = r_ir[15:13];
  assign w_sub  = r_ir[12:11];
  assign w_rn   = r_ir[10:8];
  assign w_rd   = r_ir[7:5];
  assign w_sh   = r_ir[4:3];
  assign w_rm   = r_ir[2:0];
  assign w_imm8 = r_ir[7:0];

  assign w_is_movi = (w_op == OP_MOV) && (w_sub == SUB_MOVI);
  assign w_is_movs = (w_op == OP_MOV) && (w_sub == SUB_MOVS);
  assign w_is_alu  = (w_op == OP_ALU);
  assign w_is_cmp  = w_is_alu && (w_sub == SUB_CMP);
  assign w_is_mvn  = w_is_alu && (w_sub == SUB_MVN);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_WAIT:   if (s) w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_movi)                  w_next = S_WIMM;
        else if (w_is_movs || w_is_mvn) w_next = S_GETB;
        else if (w_is_alu)              w_next = S_GETA;
        else                            w_next = S_WAIT;
      end
      S_GETA:   w_next = S_GETB;
      S_GETB:   w_next = S_EXEC;
      S_EXEC:   w_next = w_is_cmp ? S_WAIT : S_WRITE;
      S_WRITE:  w_next = S_WAIT;
      S_WIMM:   w_next = S_WAIT;
      default:  w_next = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_WAIT;
    else        r_state <= w_next;
  end

  // Shifter always acts on the B operand (Rm).
  always_comb begin
    unique case (w_sh)
      SH_PASS: w_bs = r_b;
      SH_LSL:  w_bs = {r_b[M-1:0], 1'b0};
      SH_LSR:  w_bs = {1'b0, r_b[M:1]};
      SH_ASR:  w_bs = {r_b[M], r_b[M:1]};
      default: w_bs = r_b;
    endcase
  end

  assign w_sum  = r_a + w_bs;
  assign w_diff = r_a - w_bs;

  always_comb begin
    w_res   = w_bs;
    w_res_v = 1'b0;
    if (w_is_alu) begin
      unique case (w_sub)
        SUB_ADD: begin
          w_res   = w_sum;
          w_res_v = (r_a[M] == w_bs[M]) && (w_sum[M] != r_a[M]);
        end
        SUB_CMP: begin
          w_res   = w_diff;
          w_res_v = (r_a[M] != w_bs[M]) && (w_diff[M] != r_a[M]);
        end
        SUB_AND: w_res = r_a & w_bs;
        SUB_MVN: w_res = ~w_bs;
        default: w_res = w_bs;
      endcase
    end
  end

  assign w_upd = w_is_cmp || (STATUS_ALL && w_is_alu);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_n   <= 1'b0;
      r_v   <= 1'b0;
      r_z   <= 1'b0;
      r_ill <= 1'b0;
    end else begin
      if (load) r_ir <= in;
      if (r_state == S_WAIT && s) r_ill <= 1'b0;
      if (r_state == S_DECODE && !(w_is_movi || w_is_movs || w_is_alu)) r_ill <= 1'b1;
      if (r_state == S_GETA) r_a <= w_rd_a;
      if (r_state == S_GETB) r_b <= w_rd_b;
      if (r_state == S_EXEC) begin
        r_c <= w_res;
        if (w_upd) begin
          r_n <= w_res[M];
          r_v <= w_res_v;
          r_z <= (w_res == '0);
        end
      end
    end
  end

  assign w_imm_ext = DATA_W'(sext8(w_imm8));
  assign w_we      = (r_state == S_WRITE) || (r_state == S_WIMM);
  assign w_waddr   = (r_state == S_WIMM) ? w_rn : w_rd;
  assign w_wdata   = (r_state == S_WIMM) ? w_imm_ext : r_c;

  regfile_p #(.DATA_W(DATA_W)) u_rf (
    .clk       (clk),
    .rst_n     (reset),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_rn),
    .i_raddr_b (w_rm),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

  assign out = r_c;
  assign N   = r_n;
  assign V   = r_v;
  assign Z   = r_z;
  assign w   = (r_state == S_WAIT);
  assign ill = r_ill;

endmodule

// File: tb/tb_cpu_core.sv
// Directed table-driven bench: a 16-bit STATUS_ALL=0 core and a 32-bit STATUS_ALL=1 core.
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        reset, s16, s32, load;
  logic [15:0] in;
  logic [15:0] out16;
  logic [31:0] out32;
  logic        n16, v16, z16, w16, ill16;
  logic        n32, v32, z32, w32, ill32;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cpu_core #(.DATA_W(16), .STATUS_ALL(1'b0)) u_dut16 (
    .clk(clk), .reset(reset), .s(s16), .load(load), .in(in),
    .out(out16), .N(n16), .V(v16), .Z(z16), .w(w16), .ill(ill16)
  );

  cpu_core #(.DATA_W(32), .STATUS_ALL(1'b1)) u_dut32 (
    .clk(clk), .reset(reset), .s(s32), .load(load), .in(in),
    .out(out32), .N(n32), .V(v32), .Z(z32), .w(w32), .ill(ill32)
  );

  typedef struct {
    bit          d32;
    logic [15:0] instr;
    int          lat;
    logic [63:0] eout;
    logic [2:0]  envz;
    logic        eill;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit d32, input logic [15:0] instr, input int lat,
                              input logic [63:0] eout, input logic [2:0] envz, input logic eill);
    vec_t v;
    v.d32 = d32; v.instr = instr; v.lat = lat; v.eout = eout; v.envz = envz; v.eill = eill;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] get_out(input bit d32);
    return d32 ? {32'd0, out32} : {48'd0, out16};
  endfunction

  function automatic logic [2:0] get_nvz(input bit d32);
    return d32 ? {n32, v32, z32} : {n16, v16, z16};
  endfunction

  // Counts edges after the current point until w is seen high (bounded).
  task automatic wait_w(input bit d32, output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (d32 ? w32 : w16) break;
    end
  endtask

  // Called at a negedge in WAIT: load and start on the same edge.
  task automatic issue(input bit d32, input logic [15:0] instr, output int lat);
    in = instr; load = 1'b1;
    if (d32) s32 = 1'b1; else s16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; s16 = 1'b0; s32 = 1'b0;
    if (d32 ? w32 : w16) lat = 0;
    else wait_w(d32, lat);
  endtask

  task automatic run_row(input int i);
    int lat;
    issue(tbl[i].d32, tbl[i].instr, lat);
    check($sformatf("row%0d_%h_lat", i, tbl[i].instr), 64'(lat), 64'(tbl[i].lat));
    check($sformatf("row%0d_%h_out", i, tbl[i].instr), get_out(tbl[i].d32), tbl[i].eout);
    check($sformatf("row%0d_%h_nvz", i, tbl[i].instr), 64'(get_nvz(tbl[i].d32)), 64'(tbl[i].envz));
    check($sformatf("row%0d_%h_ill", i, tbl[i].instr),
          64'(tbl[i].d32 ? ill32 : ill16), 64'(tbl[i].eill));
  endtask

  initial begin
    int lat;
    // 16-bit core, STATUS_ALL=0 (rows 0..25)
    add(0, 16'hD069, 2, 64'h0000, 3'b000, 0); // MOV R0,#0x69
    add(0, 16'hC020, 4, 64'h0069, 3'b000, 0); // MOV R1,R0
    add(0, 16'hD0CA, 2, 64'h0069, 3'b000, 0); // MOV R0,#0xCA
    add(0, 16'hC020, 4, 64'hFFCA, 3'b000, 0);
    add(0, 16'hD208, 2, 64'hFFCA, 3'b000, 0); // R2=8
    add(0, 16'hD008, 2, 64'hFFCA, 3'b000, 0); // R0=8
    add(0, 16'hC030, 4, 64'h0004, 3'b000, 0); // R1=R0 LSR
    add(0, 16'hD710, 2, 64'h0004, 3'b000, 0); // R7=16
    add(0, 16'hAA0F, 4, 64'hFFE8, 3'b100, 0); // CMP R2, R7 LSL
    add(0, 16'hAA17, 4, 64'h0000, 3'b001, 0); // CMP R2, R7 LSR
    add(0, 16'hD0FF, 2, 64'h0000, 3'b001, 0); // R0=0xFFFF
    add(0, 16'hC090, 4, 64'h7FFF, 3'b001, 0); // R4=R0 LSR
    add(0, 16'hB804, 4, 64'h8000, 3'b001, 0); // MVN R0,R4 (no flags)
    add(0, 16'hC038, 4, 64'hC000, 3'b001, 0); // R1=R0 ASR
    add(0, 16'hD6F7, 2, 64'hC000, 3'b001, 0); // R6=0xFFF7
    add(0, 16'hAE04, 4, 64'h7FF8, 3'b010, 0); // CMP R6,R4
    add(0, 16'hC0C0, 4, 64'h8000, 3'b010, 0); // R6=R0=0x8000
    add(0, 16'hAE04, 4, 64'h0001, 3'b010, 0); // CMP R6,R4
    add(0, 16'hA267, 5, 64'h0018, 3'b010, 0); // ADD R3,R2,R7
    add(0, 16'hB0A4, 5, 64'h0000, 3'b010, 0); // AND R5,R0,R4 (no flags)
    add(0, 16'hA242, 5, 64'h0010, 3'b010, 0); // ADD R2,R2,R2
    add(0, 16'hC022, 4, 64'h0010, 3'b010, 0); // R1=R2
    add(0, 16'hE000, 1, 64'h0010, 3'b010, 1); // undefined
    add(0, 16'hC800, 1, 64'h0010, 3'b010, 1); // undefined
    add(0, 16'h8000, 1, 64'h0010, 3'b010, 1); // undefined
    add(0, 16'hC022, 4, 64'h0010, 3'b010, 0); // registers intact, ill clears
    // post-reset 16-bit rows (26..27)
    add(0, 16'hC022, 4, 64'h0000, 3'b000, 0);
    add(0, 16'hAF02, 4, 64'h0000, 3'b001, 0); // CMP R7,R2 after clear
    // 32-bit core, STATUS_ALL=1 (rows 28..35)
    add(1, 16'hD080, 2, 64'h00000000, 3'b000, 0);
    add(1, 16'hC020, 4, 64'hFFFFFF80, 3'b000, 0);
    add(1, 16'hD0FF, 2, 64'hFFFFFF80, 3'b000, 0);
    add(1, 16'hC090, 4, 64'h7FFFFFFF, 3'b000, 0);
    add(1, 16'hD501, 2, 64'h7FFFFFFF, 3'b000, 0);
    add(1, 16'hA465, 5, 64'h80000000, 3'b110, 0); // ADD overflow
    add(1, 16'hB8C0, 4, 64'h00000000, 3'b001, 0); // MVN sets Z
    add(1, 16'hB4C0, 5, 64'h7FFFFFFF, 3'b000, 0); // AND clears flags

    reset = 1'b0; s16 = 1'b0; s32 = 1'b0; load = 1'b0; in = 16'h0;
    #12;
    check("rst_w16",   64'(w16), 64'd1);
    check("rst_out16", 64'(out16), 64'd0);
    check("rst_nvz16", 64'({n16, v16, z16}), 64'd0);
    check("rst_ill16", 64'(ill16), 64'd0);
    check("rst_w32",   64'(w32), 64'd1);
    check("rst_out32", 64'(out32), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 26; i++) run_row(i);

    // s held high through an ADD: ignored mid-instruction, immediate restart in WAIT
    in = 16'hA267; load = 1'b1; s16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    wait_w(0, lat);
    check("shold_lat", 64'(lat), 64'd5);
    @(posedge clk);
    @(negedge clk);
    check("shold_restart_w", 64'(w16), 64'd0);
    s16 = 1'b0;
    wait_w(0, lat);
    check("shold_lat2", 64'(lat), 64'd5);
    check("shold_out", 64'(out16), 64'h0020);

    // reset asserted while an ADD sits in GETB
    in = 16'hA267; load = 1'b1; s16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; s16 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_w",   64'(w16), 64'd1);
    check("midrst_out", 64'(out16), 64'd0);
    check("midrst_nvz", 64'({n16, v16, z16}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 26; i < tbl.size(); i++) run_row(i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
# cpu_core

Parametrised multicycle successor to the 16-bit lab CPU. It executes the same six-instruction ISA (MOV imm, MOV shift, ADD, CMP, AND, MVN) over a configurable datapath width. It adds an illegal-opcode flag and an optional mode in which every ALU instruction updates status. The block is the top-level CPU instantiated by the lab board wrapper and the directed testbenches; instruction words stay 16 bits regardless of `DATA_W`.

## Interface
- `DATA_W`, 16, datapath/register width; legal 16..64.
- `STATUS_ALL`, 0, 0: only CMP writes N/V/Z; 1: ADD, CMP, AND, MVN all write N/V/Z.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low.
- `s` in 1: start; sampled only in WAIT.
- `load` in 1: IR load enable.
- `in` in 16: instruction word.
- `out` out DATA_W: C register (last shifter/ALU result).
- `N`, `V`, `Z` out 1 each: status flags.
- `w` out 1: 1 exactly when the FSM is in WAIT.
- `ill` out 1: last accepted instruction was undefined.

## Operation
- Fields: `op[15:13]`, `sub[12:11]`, `Rn[10:8]`, `Rd[7:5]`, `sh[4:3]`, `Rm[2:0]`, `imm8[7:0]`.
- IR loads `in` on any edge with `load=1`, in any state. Decode uses IR only.
- Encodings:
  - `110_10`: Rn ← sext(imm8) to DATA_W.
  - `110_00`: Rd ← sh(Rm).
  - `101_00`: Rd ← Rn + sh(Rm).
  - `101_01`: status ← Rn − sh(Rm), no register write.
  - `101_10`: Rd ← Rn & sh(Rm).
  - `101_11`: Rd ← ~sh(Rm).
  - All other op/sub combinations are undefined.
- Shift codes: 00 pass; 01 LSL by 1 (LSB=0); 10 LSR by 1 (MSB=0); 11 ASR by 1 (MSB=old MSB).
- Arithmetic is modulo 2^DATA_W.
- Status flags:
  - N = res[DATA_W−1]; Z = (res==0).
  - Subtract: V = (A.msb≠B.msb)&&(res.msb≠A.msb).
  - Add: V = (A.msb==B.msb)&&(res.msb≠A.msb).
  - AND/MVN: V=0.
- Register file: 8×DATA_W, one write port, two read ports; cleared by reset.
- FSM states: WAIT, DECODE, GETA, GETB, EXEC, WRITE, WIMM.
  - WAIT: `s=1` → DECODE, and `ill` clears on this transition.
  - DECODE (MOV imm) → WIMM → WAIT.
  - DECODE (MOV shift, MVN) → GETB → EXEC → WRITE → WAIT.
  - DECODE (ADD, AND, CMP) → GETA → GETB → EXEC.
    - EXEC → WRITE → WAIT for ADD/AND.
    - EXEC → WAIT for CMP.
  - DECODE (undefined) → WAIT with `ill`←1; no register, C or status change.
- Register A latches in GETA, B in GETB. C latches in EXEC for every EXEC, including CMP, so `out` shows the difference after a CMP.
- Status updates in EXEC per `STATUS_ALL`.
- `s` held high in WAIT restarts immediately; `s` outside WAIT is ignored.

## Timing
- Reset (async assert): state=WAIT, `w`=1, `out`=0, N=V=Z=0, `ill`=0, R0..R7=0. IR is cleared to 0.
- Reset mid-instruction: abort with no partial write.
- Accept edge k (WAIT, s=1) → DECODE after k. Write/flag edge and `w` rise:

| Instruction | Write/flag edge | `w` rises after |
|---|---|---|
| MOV imm | k+2 | k+2 |
| MOV shift / MVN | k+4 | k+4 |
| ADD / AND | k+5 | k+5 |
| CMP (flags) | k+4 | k+4 |
| Undefined (`ill`) | k+1 | k+1 |

- `load` and `s` on the same edge in WAIT: IR updates and the FSM accepts. The executed instruction is the new IR, because decode happens in DECODE.
- Rd==Rn or Rd==Rm is legal; operands are latched before WRITE.

## Structure
- Package `cpu_pkg`:
  - opcode/sub constants;
  - shift-code constants;
  - state enum;
  - `sext8` function.
- Sub-module `regfile_p` (parameter DATA_W; 8 entries; async active-low clear; 2R1W; write on `clk`).
- Shifter, ALU and FSM stay inside `cpu_core`.

## Test plan
- DATA_W=16, load `11010_000_01101001` + s: R0=0x0069, `w` high 2 cycles after accept; imm `11001010` gives 0xFFCA.
- R2=8, `11000_000_001_10_000` with R0=8: R1=0x0004. With `sh`=11 on R0=0x8000: 0xC000.
- R2=8, R7=16, CMP `10101_010_000_01_111`: N=1, Z=0, V=0. Then `sh`=10: Z=1, N=0, V=0, out=0.
- R6=0xFFF7, R4=0x7FFF, CMP R6,R4: out=0x7FF8, V=1, N=0, Z=0. R6=0x8000 minus R4=0x7FFF: out=0x0001, V=1, N=0.
- Opcode `11100…` + s: `ill`=1 and `w` back 1 cycle later, registers and flags unchanged; next valid accept clears `ill`. `reset` low during an ADD's GETB: w=1 immediately, all registers 0.
- DATA_W=32, STATUS_ALL=1: MOV imm 0x80 gives 0xFFFFFF80. ADD 0x7FFFFFFF+1 gives out=0x80000000, V=1, N=1. A CMP-free MVN of 0xFFFFFFFF gives Z=1.
